// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    localparam int SA_MAX_WIDTH = 32;

    // Bit counter must hold WIDTH-1; a 1-bit operand still needs a 1-bit counter.
    function automatic int sa_cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the bit-slice datapath of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: walks one full_adder across WIDTH bits, LSB first,
// behind valid/ready request and result handshakes.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    localparam int CNT_W = sa_cnt_width(WIDTH);

    sa_state_t         state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  sum_sh_q, sum_sh_d;
    logic              carry_q, carry_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              start_ready_q, start_ready_d;
    logic              busy_q, busy_d;
    logic              done_valid_q, done_valid_d;

    logic              fa_sum_s;
    logic              fa_carry_s;
    logic [WIDTH-1:0]  sum_shift_s;
    logic              accept_s;
    logic              last_bit_s;

    full_adder u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .c     (carry_q),
        .sum   (fa_sum_s),
        .carry (fa_carry_s)
    );

    // New result bit enters at the MSB so the first (LSB) bit lands at bit 0.
    if (WIDTH == 1) begin : g_sum_w1
        assign sum_shift_s = fa_sum_s;
    end else begin : g_sum_wn
        assign sum_shift_s = {fa_sum_s, sum_sh_q[WIDTH-1:1]};
    end

    assign accept_s   = start_valid & start_ready_q;
    assign last_bit_s = (bit_cnt_q == CNT_W'(WIDTH - 1));

    // Next-state and datapath update for the IDLE/ADD/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sum_sh_d  = sum_sh_q;
        carry_d   = carry_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    a_sh_d    = a_in;
                    b_sh_d    = b_in;
                    carry_d   = cin;
                    sum_sh_d  = '0;
                    bit_cnt_d = '0;
                    state_d   = ADD;
                end else begin
                    state_d   = IDLE;
                end
            end
            ADD: begin
                a_sh_d    = a_sh_q >> 1'b1;
                b_sh_d    = b_sh_q >> 1'b1;
                sum_sh_d  = sum_shift_s;
                carry_d   = fa_carry_s;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (last_bit_s) begin
                    state_d = DONE;
                end else begin
                    state_d = ADD;
                end
            end
            DONE: begin
                if (done_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status flags are decoded from the next state so they can be registered.
    always_comb begin
        start_ready_d = (state_d == IDLE);
        busy_d        = (state_d == ADD) || (state_d == DONE);
        done_valid_d  = (state_d == DONE);
    end

    // State, shift registers, counter and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            a_sh_q        <= '0;
            b_sh_q        <= '0;
            sum_sh_q      <= '0;
            carry_q       <= 1'b0;
            bit_cnt_q     <= '0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            done_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_sh_q        <= a_sh_d;
            b_sh_q        <= b_sh_d;
            sum_sh_q      <= sum_sh_d;
            carry_q       <= carry_d;
            bit_cnt_q     <= bit_cnt_d;
            start_ready_q <= start_ready_d;
            busy_q        <= busy_d;
            done_valid_q  <= done_valid_d;
        end
    end

    assign start_ready = start_ready_q;
    assign busy        = busy_q;
    assign done_valid  = done_valid_q;
    assign sum_out     = sum_sh_q;
    assign cout        = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;

    logic         start_valid, start_ready, cin, busy, done_valid, done_ready, cout;
    logic [W-1:0] a_in, b_in, sum_out;

    logic         sv1, sr1, a1, b1, c1, busy1, dv1, dr1, s1, co1;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .a_in(a_in), .b_in(b_in), .cin(cin),
        .busy(busy), .done_valid(done_valid), .done_ready(done_ready),
        .sum_out(sum_out), .cout(cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst),
        .start_valid(sv1), .start_ready(sr1),
        .a_in(a1), .b_in(b1), .cin(c1),
        .busy(busy1), .done_valid(dv1), .done_ready(dr1),
        .sum_out(s1), .cout(co1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the WIDTH=8 instance against plain arithmetic.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input int hold, input bit junk);
        logic [W:0] exp;
        int k;
        exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        k = 0;
        while (start_ready !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        chk("start_ready_idle", 32'(start_ready), 32'd1);
        start_valid = 1'b1;
        a_in        = a;
        b_in        = b;
        cin         = ci;
        done_ready  = (hold == 0);
        tick();
        start_valid = junk;
        a_in        = 8'($urandom);
        b_in        = 8'($urandom);
        cin         = 1'($urandom);
        k = 0;
        while (done_valid !== 1'b1 && k < W + 4) begin
            chk("busy_ready_low", 32'(start_ready), 32'd0);
            chk("busy_high", 32'(busy), 32'd1);
            if (hold != 0) done_ready = 1'($urandom);
            tick();
            k++;
        end
        chk("latency", 32'(k), 32'(W));
        chk("sum", 32'(sum_out), 32'(exp[W-1:0]));
        chk("cout", 32'(cout), 32'(exp[W]));
        chk("done_ready_low", 32'(start_ready), 32'd0);
        if (hold != 0) begin
            done_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                tick();
                chk("hold_valid", 32'(done_valid), 32'd1);
                chk("hold_sum", 32'(sum_out), 32'(exp[W-1:0]));
                chk("hold_cout", 32'(cout), 32'(exp[W]));
            end
            done_ready = 1'b1;
        end
        tick();
        start_valid = 1'b0;
        done_ready  = 1'($urandom);
        chk("done_one_cycle", 32'(done_valid), 32'd0);
        chk("idle_not_busy", 32'(busy), 32'd0);
        chk("idle_ready", 32'(start_ready), 32'd1);
        chk("sum_kept", 32'(sum_out), 32'(exp[W-1:0]));
        chk("cout_kept", 32'(cout), 32'(exp[W]));
    endtask

    initial begin
        logic [1:0] s;
        rst         = 1'b1;
        start_valid = 1'b0;
        done_ready  = 1'b0;
        a_in        = '0;
        b_in        = '0;
        cin         = 1'b0;
        sv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; dr1 = 1'b0;
        #1;
        chk("rst_sum", 32'(sum_out), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_valid", 32'(done_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(start_ready), 32'd1);
        chk("rst_ready_w1", 32'(sr1), 32'd1);
        tick();
        tick();
        rst = 1'b0;

        run_op(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
        run_op(8'h12, 8'h34, 1'b0, 5, 1'b0);
        run_op(8'h0F, 8'h01, 1'b0, 0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        // Abort three cycles into ADD.
        start_valid = 1'b1;
        a_in        = 8'($urandom);
        b_in        = 8'($urandom);
        cin         = 1'b1;
        done_ready  = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("abort_sum", 32'(sum_out), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(start_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort_no_valid", 32'(done_valid), 32'd0);
        end
        rst = 1'b0;
        run_op(8'($urandom), 8'($urandom), 1'($urandom), 1, 1'b0);

        // Single-bit build: every operand combination.
        dr1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sv1 = 1'b1;
            a1  = i[0];
            b1  = i[1];
            c1  = i[2];
            s   = 2'(i[0]) + 2'(i[1]) + 2'(i[2]);
            chk("w1_ready", 32'(sr1), 32'd1);
            tick();
            sv1 = 1'b0;
            a1  = ~a1;
            b1  = ~b1;
            chk("w1_busy", 32'(busy1), 32'd1);
            chk("w1_not_yet", 32'(dv1), 32'd0);
            tick();
            chk("w1_valid", 32'(dv1), 32'd1);
            chk("w1_sum", 32'(s1), 32'(s[0]));
            chk("w1_cout", 32'(co1), 32'(s[1]));
            tick();
            chk("w1_done_one_cycle", 32'(dv1), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
